// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ROM-download-to-SDRAM write path.
// The queued write entry, the output FSM states and the "bank unused" start address.
package jtframe_dwnld_pkg;

    localparam logic [24:0] BANK_UNUSED = 25'h1FF_FFFF;

    typedef struct packed {
        logic [1:0]  bank;
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Mask bit set means the lane is masked, so writing lane 1 masks lane 0.
    function automatic logic [1:0] lane_mask(input logic lane);
        return lane ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_wr_if.sv
// SDRAM programming port between the download writer (master) and the SDRAM controller (slave).
// Handshake: the master raises prog_we with prog_addr/data/mask/bank stable and keeps them
// stable until it samples sdram_ack high on a clock edge; prog_rdy marks that write as finished.
interface jtframe_dwnld_wr_if;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_bank;
    logic        prog_we;
    logic        sdram_ack;
    logic        prog_rdy;

    modport master (
        output prog_addr, prog_data, prog_mask, prog_bank, prog_we,
        input  sdram_ack, prog_rdy
    );

    modport slave (
        input  prog_addr, prog_data, prog_mask, prog_bank, prog_we,
        output sdram_ack, prog_rdy
    );
endinterface

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO of pending SDRAM writes; the head entry is shown combinationally.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module jtframe_prog_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  prog_entry_t wdata,
    input  logic        pop,
    output prog_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int DEPTH = 1 << AW;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    prog_entry_t mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jtframe_dwnld_wr.sv
// Turns the ioctl ROM byte stream into SDRAM programming writes, mapping the linear image
// onto banks and queueing bytes while the controller stalls.
module jtframe_dwnld_wr
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [24:0] BA1_START = BANK_UNUSED,
    parameter logic [24:0] BA2_START = BANK_UNUSED,
    parameter logic [24:0] BA3_START = BANK_UNUSED,
    parameter int          FIFO_AW   = 2,
    parameter int          SWAB      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    jtframe_dwnld_wr_if.master prog,
    output logic              dwnld_busy,
    output logic              dwnld_err,
    output state_t            dbg_state
);

    localparam logic SWAB_BIT = (SWAB != 0);

    logic [24:0] off;
    logic [1:0]  bank;
    logic        accept;
    logic        range_err;

    prog_entry_t s1_entry_d, s1_entry_q;
    logic        s1_valid_d, s1_valid_q;

    prog_entry_t fifo_head;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic        bypass, drop_full;

    state_t      state_d, state_q;
    prog_entry_t out_d, out_q;
    logic        we_d, we_q;
    logic        err_d, err_q;
    logic        dl_q;

    // Stage 1: bank mapping, highest bank checked first.
    always_comb begin
        bank = 2'd0;
        off  = ioctl_addr;
        if (ioctl_addr >= BA3_START) begin
            bank = 2'd3;
            off  = ioctl_addr - BA3_START;
        end else if (ioctl_addr >= BA2_START) begin
            bank = 2'd2;
            off  = ioctl_addr - BA2_START;
        end else if (ioctl_addr >= BA1_START) begin
            bank = 2'd1;
            off  = ioctl_addr - BA1_START;
        end
        s1_entry_d.bank = bank;
        s1_entry_d.addr = off[22:1];
        s1_entry_d.data = ioctl_data;
        s1_entry_d.mask = lane_mask(off[0] ^ SWAB_BIT);
        accept     = downloading && ioctl_wr;
        range_err  = accept && (off[24:23] != 2'b00);
        s1_valid_d = accept && !range_err;
    end

    // With nothing queued and the FSM idle, stage 1 goes straight to the output registers.
    assign bypass    = (state_q == IDLE) && fifo_empty && s1_valid_q;
    assign fifo_push = s1_valid_q && !bypass && (!fifo_full || fifo_pop);
    assign drop_full = s1_valid_q && !bypass && fifo_full && !fifo_pop;

    jtframe_prog_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (s1_entry_q),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        err_d = ((downloading && !dl_q) ? 1'b0 : err_q) | range_err | drop_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_q      <= '0;
            we_q       <= 1'b0;
            s1_entry_q <= '0;
            s1_valid_q <= 1'b0;
            err_q      <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            we_q       <= we_d;
            s1_entry_q <= s1_entry_d;
            s1_valid_q <= s1_valid_d;
            err_q      <= err_d;
            dl_q       <= downloading;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!fifo_empty || s1_valid_q) state_d = REQ;
            REQ:  if (prog.sdram_ack) state_d = prog.prog_rdy ? IDLE : WAIT;
            WAIT: if (prog.prog_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The queue head is older than stage 1, so it is always served first.
    always_comb begin
        out_d    = out_q;
        we_d     = we_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    out_d    = fifo_head;
                    fifo_pop = 1'b1;
                    we_d     = 1'b1;
                end else if (s1_valid_q) begin
                    out_d = s1_entry_q;
                    we_d  = 1'b1;
                end
            end
            REQ: if (prog.sdram_ack) we_d = 1'b0;
            default: we_d = 1'b0;
        endcase
    end

    assign prog.prog_addr = out_q.addr;
    assign prog.prog_data = out_q.data;
    assign prog.prog_mask = out_q.mask;
    assign prog.prog_bank = out_q.bank;
    assign prog.prog_we   = we_q;

    assign dwnld_busy = downloading || s1_valid_q || !fifo_empty || (state_q != IDLE);
    assign dwnld_err  = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_jtframe_dwnld_wr.sv
// Directed bench for jtframe_dwnld_wr: a vector table of single-byte writes plus
// hand-written sequences for stalls, drops, gating, reset and byte swapping.
module tb_jtframe_dwnld_wr;
    import jtframe_dwnld_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        busy_a, err_a, busy_b, err_b;
    state_t      st_a, st_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    jtframe_dwnld_wr_if bus_a ();
    jtframe_dwnld_wr_if bus_b ();

    // The swapped instance answers every request at once.
    assign bus_b.sdram_ack = bus_b.prog_we;
    assign bus_b.prog_rdy  = bus_b.prog_we;

    jtframe_dwnld_wr #(
        .BA1_START (25'h008_0000),
        .BA2_START (25'h010_0000),
        .FIFO_AW   (2),
        .SWAB      (0)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog        (bus_a),
        .dwnld_busy  (busy_a),
        .dwnld_err   (err_a),
        .dbg_state   (st_a)
    );

    jtframe_dwnld_wr #(
        .FIFO_AW (2),
        .SWAB    (1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog        (bus_b),
        .dwnld_busy  (busy_b),
        .dwnld_err   (err_b),
        .dbg_state   (st_b)
    );

    int         b_cnt = 0;
    logic [1:0] b_mask = '0;
    logic [21:0] b_addr = '0;
    always @(negedge clk) begin
        if (bus_b.prog_we) begin
            b_cnt  <= b_cnt + 1;
            b_mask <= bus_b.prog_mask;
            b_addr <= bus_b.prog_addr;
        end
    end

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [1:0]  bank;
        logic [21:0] waddr;
        logic [1:0]  mask;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    // Returns the ioctl_wr-to-prog_we latency in cycles, 99 if prog_we never rose.
    task automatic wait_we(output int lat);
        lat = 99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_a.prog_we) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        bus_a.sdram_ack = 1'b1;
        @(negedge clk);
        bus_a.sdram_ack = 1'b0;
        bus_a.prog_rdy  = 1'b1;
        @(negedge clk);
        bus_a.prog_rdy  = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        int nwr;
        int last_c;
        bit saw_wait;
        logic [7:0] exp_d;

        vecs[0] = '{25'h000_0003, 8'hA5, 2'd0, 22'h000001, 2'b01};
        vecs[1] = '{25'h007_FFFF, 8'h11, 2'd0, 22'h03FFFF, 2'b01};
        vecs[2] = '{25'h008_0000, 8'h22, 2'd1, 22'h000000, 2'b10};
        vecs[3] = '{25'h010_0001, 8'h33, 2'd2, 22'h000000, 2'b01};
        vecs[4] = '{25'h000_0000, 8'h44, 2'd0, 22'h000000, 2'b10};
        vecs[5] = '{25'h017_FFFE, 8'h55, 2'd2, 22'h03FFFF, 2'b10};
        vecs[6] = '{25'h00F_FFFF, 8'h66, 2'd1, 22'h03FFFF, 2'b01};
        vecs[7] = '{25'h1FF_FFFF, 8'h77, 2'd3, 22'h000000, 2'b10};

        bus_a.sdram_ack = 1'b0;
        bus_a.prog_rdy  = 1'b0;
        repeat (3) step();
        chk("rst_we",    {31'd0, bus_a.prog_we}, 32'd0);
        chk("rst_addr",  {10'd0, bus_a.prog_addr}, 32'd0);
        chk("rst_data",  {24'd0, bus_a.prog_data}, 32'd0);
        chk("rst_mask",  {30'd0, bus_a.prog_mask}, 32'd0);
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_err",   {31'd0, err_a}, 32'd0);
        chk("rst_state", {30'd0, st_a}, {30'd0, IDLE});
        rst_n = 1'b1;
        step();

        // Byte swap: same address seen by both instances.
        downloading = 1'b1;
        step();
        send_byte(25'h0, 8'h5A);
        wait_we(lat);
        chk("swab_lat_a",  lat, 32'd2);
        chk("swab_mask_a", {30'd0, bus_a.prog_mask}, 32'h2);
        handshake();
        chk("swab_cnt_b",  b_cnt, 32'd1);
        chk("swab_mask_b", {30'd0, b_mask}, 32'h1);
        chk("swab_addr_b", {10'd0, b_addr}, 32'd0);

        // Single byte with ack after 1 cycle and rdy 3 cycles after ack.
        send_byte(25'h000_0003, 8'hA5);
        wait_we(lat);
        chk("sb_lat",  lat, 32'd2);
        chk("sb_addr", {10'd0, bus_a.prog_addr}, 32'h1);
        chk("sb_mask", {30'd0, bus_a.prog_mask}, 32'h1);
        chk("sb_bank", {30'd0, bus_a.prog_bank}, 32'h0);
        chk("sb_data", {24'd0, bus_a.prog_data}, 32'hA5);
        @(negedge clk);
        bus_a.sdram_ack = 1'b1;
        @(negedge clk);
        bus_a.sdram_ack = 1'b0;
        chk("sb_we_drop", {31'd0, bus_a.prog_we}, 32'd0);
        chk("sb_wait",    {30'd0, st_a}, {30'd0, WAIT});
        downloading = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_a.prog_rdy = 1'b1;
        chk("sb_busy_before", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        bus_a.prog_rdy = 1'b0;
        chk("sb_busy_after", {31'd0, busy_a}, 32'd0);
        chk("sb_idle",       {30'd0, st_a}, {30'd0, IDLE});
        chk("sb_data_held",  {24'd0, bus_a.prog_data}, 32'hA5);
        step();
        downloading = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            send_byte(vecs[v].addr, vecs[v].data);
            wait_we(lat);
            chk($sformatf("vec%0d_lat", v),  lat, 32'd2);
            chk($sformatf("vec%0d_bank", v), {30'd0, bus_a.prog_bank}, {30'd0, vecs[v].bank});
            chk($sformatf("vec%0d_addr", v), {10'd0, bus_a.prog_addr}, {10'd0, vecs[v].waddr});
            chk($sformatf("vec%0d_mask", v), {30'd0, bus_a.prog_mask}, {30'd0, vecs[v].mask});
            chk($sformatf("vec%0d_data", v), {24'd0, bus_a.prog_data}, {24'd0, vecs[v].data});
            handshake();
        end

        // Offset beyond 8 MB in bank 2: dropped with a sticky error.
        send_byte(25'h090_0000, 8'hEE);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.prog_we) seen++;
        end
        chk("range_no_we", seen, 32'd0);
        chk("range_err",   {31'd0, err_a}, 32'd1);
        step();
        downloading = 1'b0;
        step();
        downloading = 1'b1;
        step();
        @(negedge clk);
        chk("range_err_clear", {31'd0, err_a}, 32'd0);
        step();

        // Backpressure: 6 bytes into a 4-deep queue while the controller stalls.
        for (int i = 0; i < 6; i++) begin
            ioctl_addr = 25'h20 + 25'(i);
            ioctl_data = 8'hC0 + 8'(i);
            ioctl_wr   = 1'b1;
            if (i < 5) exp_q.push_back(8'hC0 + 8'(i));
            step();
        end
        ioctl_wr = 1'b0;
        repeat (3) step();
        chk("bp_err",   {31'd0, err_a}, 32'd1);
        chk("bp_state", {30'd0, st_a}, {30'd0, REQ});
        chk("bp_head",  {10'd0, bus_a.prog_addr}, 32'h10);
        nwr = 0;
        last_c = 0;
        saw_wait = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (st_a == WAIT) saw_wait = 1'b1;
            if (bus_a.sdram_ack) begin
                bus_a.sdram_ack = 1'b0;
                bus_a.prog_rdy  = 1'b0;
            end else if (bus_a.prog_we) begin
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    chk($sformatf("bp_data%0d", nwr), {24'd0, bus_a.prog_data}, {24'd0, exp_d});
                end
                if (nwr > 0) chk($sformatf("bp_gap%0d", nwr), c - last_c, 32'd2);
                last_c = c;
                nwr++;
                bus_a.sdram_ack = 1'b1;
                bus_a.prog_rdy  = 1'b1;
            end
        end
        chk("bp_count",   nwr, 32'd5);
        chk("bp_no_wait", {31'd0, saw_wait}, 32'd0);
        chk("bp_queue",   exp_q.size(), 32'd0);
        chk("bp_err_held", {31'd0, err_a}, 32'd1);
        step();
        downloading = 1'b0;
        step();
        downloading = 1'b1;
        step();
        @(negedge clk);
        chk("bp_err_clear", {31'd0, err_a}, 32'd0);
        step();

        // Gating: strobes outside the download window are ignored.
        downloading = 1'b0;
        step();
        send_byte(25'h40, 8'h99);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.prog_we) seen++;
        end
        chk("gate_no_we", seen, 32'd0);
        chk("gate_busy",  {31'd0, busy_a}, 32'd0);
        step();

        // Reset while a request is pending with entries queued behind it.
        downloading = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            ioctl_addr = 25'h50 + 25'(i);
            ioctl_data = 8'h30 + 8'(i);
            ioctl_wr   = 1'b1;
            step();
        end
        ioctl_wr = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rq_we_before", {31'd0, bus_a.prog_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rq_we_async", {31'd0, bus_a.prog_we}, 32'd0);
        chk("rq_state",    {30'd0, st_a}, {30'd0, IDLE});
        step();
        downloading = 1'b0;
        rst_n = 1'b1;
        step();
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.prog_we) seen++;
        end
        chk("rq_no_we",   seen, 32'd0);
        chk("rq_empty",   {31'd0, busy_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
